// File: rtl/hist_eq_stream.sv
// Two-pass streaming histogram equaliser: pass 1 accumulates the histogram,
// then CDF and LUT are built in place, and pass 2 remaps pixels through the LUT.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | zeroing one histogram bin per cycle
// ACCUM | pass 1, counting pixels into bins
// CDF   | in-place prefix sum, capturing the first nonzero CDF value
// LUT   | per-bin rounded divide (or identity when den is 0)
// MAP   | pass 2, one-deep output register through the LUT
module hist_eq_stream #(
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 76800,
  parameter int CNT_W   = $clog2(NUM_PIX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             busy,
  output logic             done
);

  localparam int NB  = 1 << PIX_W;
  localparam int NW  = CNT_W + PIX_W;
  localparam int DW  = NW + 1;
  localparam int DCW = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIX);
  localparam logic [PIX_W-1:0] BIN_LAST  = PIX_W'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_CDF, S_LUT, S_MAP
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] in_left_q, in_left_d;
  logic [CNT_W-1:0] out_left_q, out_left_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cdf_min_q, cdf_min_d;
  logic             min_found_q, min_found_d;
  logic             div_run_q, div_run_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [DW-1:0]    rem_q, rem_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             done_q, done_d;

  // Histogram storage is reused in place for the CDF.
  logic [CNT_W-1:0] hist_q [NB];
  logic [PIX_W-1:0] lut_q  [NB];

  logic             hist_we, lut_we;
  logic [PIX_W-1:0] hist_waddr, lut_waddr;
  logic [CNT_W-1:0] hist_wdata;
  logic [PIX_W-1:0] lut_wdata;

  logic [CNT_W-1:0] den, cdf_cur, cdf_acc;
  logic [NW-1:0]    diff_w, num;
  logic [DW:0]      dsr, rem_sh;
  logic             qbit, sat;
  logic             out_hs, in_hs;

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    in_left_d   = in_left_q;
    out_left_d  = out_left_q;
    run_d       = run_q;
    cdf_min_d   = cdf_min_q;
    min_found_d = min_found_q;
    div_run_d   = div_run_q;
    div_cnt_d   = div_cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    hist_we     = 1'b0;
    hist_waddr  = bin_q;
    hist_wdata  = '0;
    lut_we      = 1'b0;
    lut_waddr   = bin_q;
    lut_wdata   = '0;

    den     = NUM_PIX_C - cdf_min_q;
    cdf_cur = hist_q[bin_q];
    cdf_acc = (bin_q == '0) ? cdf_cur : run_q + cdf_cur;
    diff_w  = NW'(cdf_cur - cdf_min_q);
    // (cdf - cdf_min) * (NB-1) as a shift and subtract
    num     = (cdf_cur < cdf_min_q) ? '0 : (diff_w << PIX_W) - diff_w;
    dsr     = {{(DW - CNT_W){1'b0}}, den, 1'b0};
    rem_sh  = {rem_q, dvd_q[DW-1]};
    qbit    = (rem_sh >= dsr);
    sat     = (quo_q > DW'(NB - 1));
    out_hs  = out_valid_q && out_ready;
    in_hs   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          bin_d   = '0;
        end
      end
      S_CLEAR: begin
        hist_we = 1'b1;
        if (bin_q == BIN_LAST) begin
          state_d   = S_ACCUM;
          bin_d     = '0;
          in_left_d = NUM_PIX_C;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Single-cycle read-modify-write, so repeated bins see the fresh count.
          hist_we    = 1'b1;
          hist_waddr = in_pix;
          hist_wdata = hist_q[in_pix] + 1'b1;
          in_left_d  = in_left_q - 1'b1;
          if (in_left_q == CNT_W'(1)) begin
            state_d     = S_CDF;
            bin_d       = '0;
            cdf_min_d   = '0;
            min_found_d = 1'b0;
          end
        end
      end
      S_CDF: begin
        hist_we    = 1'b1;
        hist_wdata = cdf_acc;
        run_d      = cdf_acc;
        if (!min_found_q && cdf_acc != '0) begin
          cdf_min_d   = cdf_acc;
          min_found_d = 1'b1;
        end
        if (bin_q == BIN_LAST) begin
          state_d   = S_LUT;
          bin_d     = '0;
          div_run_d = 1'b0;
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end
      S_LUT: begin
        if (div_run_q && div_cnt_q != '0) begin
          rem_d     = qbit ? DW'(rem_sh - dsr) : DW'(rem_sh);
          dvd_d     = {dvd_q[DW-2:0], 1'b0};
          quo_d     = {quo_q[DW-2:0], qbit};
          div_cnt_d = div_cnt_q - 1'b1;
        end else if (!div_run_q && den != '0) begin
          // Round half up: floor((2*num + den) / (2*den))
          dvd_d     = {num, 1'b0} + DW'(den);
          rem_d     = '0;
          quo_d     = '0;
          div_cnt_d = DCW'(DW);
          div_run_d = 1'b1;
        end else begin
          lut_we    = 1'b1;
          lut_wdata = (den == '0) ? bin_q : (sat ? BIN_LAST : quo_q[PIX_W-1:0]);
          div_run_d = 1'b0;
          if (bin_q == BIN_LAST) begin
            state_d    = S_MAP;
            bin_d      = '0;
            in_left_d  = NUM_PIX_C;
            out_left_d = NUM_PIX_C;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end
      end
      S_MAP: begin
        in_ready = (in_left_q != '0) && (!out_valid_q || out_ready);
        in_hs    = in_ready && in_valid;
        if (in_hs) begin
          out_pix_d   = lut_q[in_pix];
          out_valid_d = 1'b1;
          in_left_d   = in_left_q - 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (out_hs) begin
          out_left_d = out_left_q - 1'b1;
          if (out_left_q == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      in_left_q   <= '0;
      out_left_q  <= '0;
      run_q       <= '0;
      cdf_min_q   <= '0;
      min_found_q <= 1'b0;
      div_run_q   <= 1'b0;
      div_cnt_q   <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      in_left_q   <= in_left_d;
      out_left_q  <= out_left_d;
      run_q       <= run_d;
      cdf_min_q   <= cdf_min_d;
      min_found_q <= min_found_d;
      div_run_q   <= div_run_d;
      div_cnt_q   <= div_cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hist_we) hist_q[hist_waddr] <= hist_wdata;
    if (lut_we)  lut_q[lut_waddr]   <= lut_wdata;
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
